// File: rtl/keyboard_matrix_responder_if.sv
// keyboard_matrix_responder_if: host key-event handshake, modifier levels and POKEY scan lines
// Signals:
//   key_valid/key_ready/key_code/key_make  host make/break event handshake
//   shift_in/ctrl_in/break_in              host modifier levels
//   key_scan_L                             POKEY scan lines, active low
//   kr1_L/kr2_L                            key-return lines back to POKEY
//   any_key                                OR of the pressed bitmap
// Modports: master = host/POKEY side, slave = responder.
interface keyboard_matrix_responder_if #(
    parameter int SCAN_BITS = 6
);
    logic [SCAN_BITS-1:0] key_scan_L;
    logic                 kr1_L;
    logic                 kr2_L;
    logic                 key_valid;
    logic                 key_ready;
    logic [SCAN_BITS-1:0] key_code;
    logic                 key_make;
    logic                 shift_in;
    logic                 ctrl_in;
    logic                 break_in;
    logic                 any_key;

    modport master (
        output key_scan_L, key_valid, key_code, key_make, shift_in, ctrl_in, break_in,
        input  kr1_L, kr2_L, key_ready, any_key
    );

    modport slave (
        input  key_scan_L, key_valid, key_code, key_make, shift_in, ctrl_in, break_in,
        output kr1_L, kr2_L, key_ready, any_key
    );
endinterface

// File: rtl/keyboard_matrix_responder.sv
// keyboard_matrix_responder: Atari keyboard matrix answering POKEY scans from host make/break events
// Ports:
//   o2   system clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  slave side of keyboard_matrix_responder_if (event handshake, modifiers,
//        scan lines in, kr1_L/kr2_L/any_key out)
module keyboard_matrix_responder #(
    parameter int                   SCAN_BITS = 6,
    parameter int                   MIN_SCANS = 2,
    parameter logic [SCAN_BITS-1:0] SHIFT_IDX = 6'd16,
    parameter logic [SCAN_BITS-1:0] CTRL_IDX  = 6'd0,
    parameter logic [SCAN_BITS-1:0] BREAK_IDX = 6'd48
) (
    input logic                        o2,
    input logic                        rst,
    keyboard_matrix_responder_if.slave bus
);
    localparam int KEYS = 1 << SCAN_BITS;
    localparam int CW   = MIN_SCANS > 0 ? $clog2(MIN_SCANS + 1) : 1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [KEYS-1:0]      pressed_q, pressed_d;
    logic [CW-1:0]        wrap_cnt_q, wrap_cnt_d;
    logic [SCAN_BITS-1:0] idx, prev_idx_q;
    logic                 shift_q, ctrl_q, break_q;
    logic                 wrap, hold_done;

    assign idx  = ~bus.key_scan_L;
    // A scan pass completes when the index lands on 0 coming from anywhere else;
    // a scan parked on one index therefore never completes a pass.
    assign wrap = idx == '0 && prev_idx_q != '0;
    // HOLD ends on the edge that would bring wrap_cnt to MIN_SCANS; with no
    // required passes it lasts a single cycle.
    assign hold_done = MIN_SCANS == 0 || (wrap && wrap_cnt_q == CW'(MIN_SCANS - 1));

    always_comb begin
        state_d    = state_q;
        pressed_d  = pressed_q;
        wrap_cnt_d = wrap_cnt_q;
        if (state_q == IDLE) begin
            if (bus.key_valid) begin
                pressed_d[bus.key_code] = bus.key_make;
                wrap_cnt_d              = '0;
                state_d                 = HOLD;
            end
        end else begin
            wrap_cnt_d = wrap ? wrap_cnt_q + CW'(1) : wrap_cnt_q;
            state_d    = hold_done ? IDLE : HOLD;
        end
    end

    always_ff @(posedge o2 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pressed_q  <= '0;
            wrap_cnt_q <= '0;
            prev_idx_q <= '1;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            break_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            wrap_cnt_q <= wrap_cnt_d;
            prev_idx_q <= idx;
            shift_q    <= bus.shift_in;
            ctrl_q     <= bus.ctrl_in;
            break_q    <= bus.break_in;
        end
    end

    // Both return lines are combinational from the scan index so POKEY sees the
    // answer for the index it drives within the same cycle.
    assign bus.kr1_L     = ~pressed_q[idx];
    assign bus.kr2_L     = ~((idx == SHIFT_IDX && shift_q) || (idx == CTRL_IDX && ctrl_q) ||
                             (idx == BREAK_IDX && break_q));
    assign bus.key_ready = state_q == IDLE;
    assign bus.any_key   = |pressed_q;
endmodule

// File: tb/tb_keyboard_matrix_responder.sv
// tb_keyboard_matrix_responder: directed scan/event sequences with a queue-based scoreboard
module tb_keyboard_matrix_responder;
    logic o2;
    logic rst;

    keyboard_matrix_responder_if #(.SCAN_BITS(6)) bus ();

    keyboard_matrix_responder dut (
        .o2  (o2),
        .rst (rst),
        .bus (bus)
    );

    initial o2 = 1'b0;
    always #5 o2 = ~o2;

    typedef struct {
        string tag;
        int    idx;
        logic  kr1;
        logic  kr2;
        logic  rdy;
        logic  any;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cur = 63;
    logic [63:0] mp = '0;
    logic        ms = 1'b0;
    logic        mc = 1'b0;
    logic        mb = 1'b0;
    logic        rdy = 1'b1;

    task automatic step(input int i);
        @(posedge o2);
        #1;
        cur = i;
        bus.key_scan_L = ~6'(i);
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.idx = cur;
        e.kr1 = ~mp[cur];
        e.kr2 = ~((cur == 16 && ms) || (cur == 0 && mc) || (cur == 48 && mb));
        e.rdy = rdy;
        e.any = |mp;
        q.push_back(e);
    endtask

    // Drive scan indices lo..hi; optionally issue one event at ev_at (accepted on
    // the following edge) and expect ready to return at rdy_at.
    task automatic pass(input int lo, input int hi, input int rdy_at, input int ev_at,
                        input int code, input logic make, input string tag);
        for (int i = lo; i <= hi; i++) begin
            step(i);
            if (i == ev_at + 1) begin
                bus.key_valid = 1'b0;
                mp[code] = make;
                rdy = 1'b0;
            end
            if (i == rdy_at) rdy = 1'b1;
            if (i == ev_at) begin
                bus.key_valid = 1'b1;
                bus.key_code = 6'(code);
                bus.key_make = make;
            end
            push(tag);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge o2);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({bus.kr1_L, bus.kr2_L, bus.key_ready, bus.any_key} !== {e.kr1, e.kr2, e.rdy, e.any}) begin
                    errors++;
                    $display("FAIL %s idx=%0d got kr1_L=%b kr2_L=%b key_ready=%b any_key=%b expected %b %b %b %b",
                             e.tag, e.idx, bus.kr1_L, bus.kr2_L, bus.key_ready, bus.any_key,
                             e.kr1, e.kr2, e.rdy, e.any);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.key_scan_L = '0;
        bus.key_valid = 1'b0;
        bus.key_code = '0;
        bus.key_make = 1'b0;
        bus.shift_in = 1'b0;
        bus.ctrl_in = 1'b0;
        bus.break_in = 1'b0;
        step(63); push("reset");
        step(63); rst = 1'b0; push("reset");

        pass(60, 63, -1, 60, 5, 1'b1, "press5");
        pass(0, 63, -1, -9, 0, 1'b0, "press5_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "press5_pass2");

        pass(0, 63, -1, 0, 40, 1'b1, "press40");
        pass(0, 63, -1, -9, 0, 1'b0, "press40_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "press40_pass2");
        pass(0, 63, -1, 3, 5, 1'b0, "release5");
        pass(0, 63, -1, -9, 0, 1'b0, "release5_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "release5_pass2");

        step(16); bus.shift_in = 1'b1; bus.break_in = 1'b1; push("mod_lat0");
        step(16); ms = 1'b1; mb = 1'b1; push("mod_lat1");
        pass(0, 63, -1, -9, 0, 1'b0, "mod_pass");
        step(17); bus.shift_in = 1'b0; bus.break_in = 1'b0; push("mod_clr0");
        step(16); ms = 1'b0; mb = 1'b0; push("mod_clr1");

        pass(0, 63, -1, 10, 20, 1'b1, "press20");
        for (int i = 0; i <= 63; i++) begin
            step(i);
            if (i == 30) begin
                bus.key_valid = 1'b1;
                bus.key_code = 6'd33;
                bus.key_make = 1'b1;
            end
            push("held_in_hold");
        end
        pass(0, 63, 1, 1, 33, 1'b1, "held_accept");
        pass(0, 63, -1, -9, 0, 1'b0, "held_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "held_pass2");

        pass(0, 7, -1, 5, 20, 1'b1, "redundant_make");
        repeat (150) begin step(7); push("stall"); end
        pass(8, 63, -1, -9, 0, 1'b0, "resume");
        pass(0, 63, -1, -9, 0, 1'b0, "resume_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "resume_pass2");

        pass(0, 19, -1, 3, 9, 1'b0, "redundant_break");
        step(20); rst = 1'b1; mp = '0; rdy = 1'b1; push("async_rst");
        pass(21, 63, -1, -9, 0, 1'b0, "rst_held");
        pass(0, 63, -1, -9, 0, 1'b0, "rst_held");
        step(0); rst = 1'b0; push("rst_release");
        pass(1, 63, -1, 2, 1, 1'b1, "post_rst_press");
        pass(0, 63, -1, -9, 0, 1'b0, "post_rst_pass1");
        pass(0, 63, 1, -9, 0, 1'b0, "post_rst_pass2");

        @(negedge o2);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
